// File: rtl/led_pattern_sequencer_if.sv
// Switch/LED bundle between the board pins and the LED pattern sequencer.
// The sequencer takes the slave modport; whatever drives the switches takes the master modport.
interface led_pattern_sequencer_if;
  logic [3:0] switches;
  logic [3:0] leds;
  logic [1:0] mode;
  logic       tick;

  modport master (
    output switches,
    input  leds,
    input  mode,
    input  tick
  );

  modport slave (
    input  switches,
    output leds,
    output mode,
    output tick
  );
endinterface

// File: rtl/led_pattern_sequencer.sv
// LED pattern sequencer: synchronises and debounces the slide switches, decodes the mode,
// and steps a pattern state machine from a pausable prescaled tick.
module led_pattern_sequencer #(
  parameter int unsigned TICK_DIV        = 25_000_000,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic                   board_clk,
  input  logic                   board_rst_n,
  led_pattern_sequencer_if.slave io
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [PW-1:0] TICK_MAX = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] DEB_MAX  = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_OFF      = 3'd0,
    ST_COUNT    = 3'd1,
    ST_BOUNCE_L = 3'd2,
    ST_BOUNCE_R = 3'd3,
    ST_BLINK    = 3'd4
  } state_t;

  logic [3:0]    sync1_q, sync2_q;
  logic [3:0]    deb_q, deb_d;
  logic [CW-1:0] deb_cnt_q [4];
  logic [CW-1:0] deb_cnt_d [4];
  state_t        state_q, state_d;
  logic [3:0]    leds_q, leds_d;
  logic [1:0]    mode_q, mode_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          tick_q, tick_d;
  logic          pause_s, variant_s;

  assign pause_s   = deb_q[2];
  assign variant_s = deb_q[3];

  // Two-flop synchroniser for the raw switch inputs.
  always_ff @(posedge board_clk or negedge board_rst_n) begin
    if (!board_rst_n) begin
      sync1_q <= 4'b0000;
      sync2_q <= 4'b0000;
    end else begin
      sync1_q <= io.switches;
      sync2_q <= sync1_q;
    end
  end

  // Per-bit debounce: a change is accepted after DEBOUNCE_CYCLES consecutive differing samples.
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < 4; i++) begin
      deb_cnt_d[i] = deb_cnt_q[i];
      if (sync2_q[i] != deb_q[i]) begin
        if (deb_cnt_q[i] == DEB_MAX) begin
          deb_d[i]     = sync2_q[i];
          deb_cnt_d[i] = {CW{1'b0}};
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + CW'(1);
        end
      end else begin
        deb_cnt_d[i] = {CW{1'b0}};
      end
    end
  end

  // Debounced switch values and their stability counters.
  always_ff @(posedge board_clk or negedge board_rst_n) begin
    if (!board_rst_n) begin
      deb_q <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        deb_cnt_q[i] <= {CW{1'b0}};
      end
    end else begin
      deb_q <= deb_d;
      for (int i = 0; i < 4; i++) begin
        deb_cnt_q[i] <= deb_cnt_d[i];
      end
    end
  end

  // Next state: mode entry outranks a coincident tick and applies even while paused.
  always_comb begin
    state_d = state_q;
    leds_d  = leds_q;
    mode_d  = mode_q;
    presc_d = presc_q;
    if (deb_q[1:0] != mode_q) begin
      mode_d  = deb_q[1:0];
      presc_d = {PW{1'b0}};
      case (deb_q[1:0])
        2'b00: begin
          state_d = ST_OFF;
          leds_d  = 4'b0000;
        end
        2'b01: begin
          state_d = ST_COUNT;
          leds_d  = 4'b0000;
        end
        2'b10: begin
          state_d = ST_BOUNCE_L;
          leds_d  = 4'b0001;
        end
        2'b11: begin
          state_d = ST_BLINK;
          leds_d  = variant_s ? 4'b0101 : 4'b0000;
        end
        default: begin
          state_d = ST_OFF;
          leds_d  = 4'b0000;
        end
      endcase
    end else if (state_q == ST_OFF) begin
      presc_d = {PW{1'b0}};
      leds_d  = 4'b0000;
    end else if (pause_s) begin
      presc_d = presc_q;
    end else if (presc_q == TICK_MAX) begin
      presc_d = {PW{1'b0}};
      case (state_q)
        ST_COUNT: begin
          if (variant_s) begin
            leds_d = leds_q - 4'd1;
          end else begin
            leds_d = leds_q + 4'd1;
          end
        end
        ST_BOUNCE_L: begin
          if (leds_q == 4'b1000) begin
            leds_d  = 4'b0100;
            state_d = ST_BOUNCE_R;
          end else begin
            leds_d = {leds_q[2:0], 1'b0};
          end
        end
        ST_BOUNCE_R: begin
          if (leds_q == 4'b0001) begin
            leds_d  = 4'b0010;
            state_d = ST_BOUNCE_L;
          end else begin
            leds_d = {1'b0, leds_q[3:1]};
          end
        end
        ST_BLINK: begin
          leds_d = ~leds_q;
        end
        default: begin
          state_d = ST_OFF;
          leds_d  = 4'b0000;
        end
      endcase
    end else begin
      presc_d = presc_q + PW'(1);
    end
    // Registered strobe: high exactly while the stored count sits at TICK_MAX and we run.
    tick_d = (state_d != ST_OFF) && !deb_d[2] && (presc_d == TICK_MAX);
  end

  // Sequencer state, pattern, mode and tick registers.
  always_ff @(posedge board_clk or negedge board_rst_n) begin
    if (!board_rst_n) begin
      state_q <= ST_OFF;
      leds_q  <= 4'b0000;
      mode_q  <= 2'b00;
      presc_q <= {PW{1'b0}};
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      leds_q  <= leds_d;
      mode_q  <= mode_d;
      presc_q <= presc_d;
      tick_q  <= tick_d;
    end
  end

  assign io.leds = leds_q;
  assign io.mode = mode_q;
  assign io.tick = tick_q;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Self-checking bench for led_pattern_sequencer: directed scenarios plus random switch
// activity, compared every cycle against a behavioural reference model.
module tb_led_pattern_sequencer;
  localparam int D   = 4;
  localparam int DIV = 5;

  logic board_clk;
  logic board_rst_n;
  led_pattern_sequencer_if bus ();

  led_pattern_sequencer #(.TICK_DIV(DIV), .DEBOUNCE_CYCLES(D)) dut (
    .board_clk  (board_clk),
    .board_rst_n(board_rst_n),
    .io         (bus)
  );

  initial board_clk = 1'b0;
  always #5 board_clk = ~board_clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state
  int m_mode, m_leds, m_presc, m_pos, m_deb, m_tick;
  int hist[$];
  int bounce_tbl[6] = '{1, 2, 4, 8, 4, 2};

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_leds = 0; m_presc = 0; m_pos = 0; m_deb = 0; m_tick = 0;
    hist.delete();
    repeat (D + 2) hist.push_back(0);
  endtask

  task automatic model_edge(input int sw);
    int dm, pause, variant, new_deb, last;
    bit all_diff;
    dm      = m_deb & 3;
    pause   = (m_deb >> 2) & 1;
    variant = (m_deb >> 3) & 1;
    if (dm != m_mode) begin
      m_mode = dm; m_presc = 0; m_pos = 0;
      if (dm == 2) m_leds = 1;
      else if (dm == 3) m_leds = variant ? 5 : 0;
      else m_leds = 0;
    end else if (m_mode != 0 && pause == 0) begin
      if (m_presc == DIV - 1) begin
        m_presc = 0;
        if (m_mode == 1) m_leds = (m_leds + (variant ? 15 : 1)) % 16;
        else if (m_mode == 2) begin
          m_pos  = (m_pos + 1) % 6;
          m_leds = bounce_tbl[m_pos];
        end else m_leds = m_leds ^ 15;
      end else begin
        m_presc++;
      end
    end
    // A bit flips once the synchronised input has disagreed with it for D straight samples.
    new_deb = m_deb;
    last = hist.size() - 1;
    for (int b = 0; b < 4; b++) begin
      all_diff = 1'b1;
      for (int j = 1; j <= D; j++)
        if (((hist[last - j] >> b) & 1) == ((m_deb >> b) & 1)) all_diff = 1'b0;
      if (all_diff) new_deb = new_deb ^ (1 << b);
    end
    m_deb = new_deb;
    hist.push_back(sw);
    if (hist.size() > 32) void'(hist.pop_front());
    m_tick = (m_mode != 0 && ((m_deb >> 2) & 1) == 0 && m_presc == DIV - 1) ? 1 : 0;
  endtask

  task automatic cycle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge board_clk);
      if (board_rst_n) model_edge(int'(bus.switches));
      else model_reset();
      @(negedge board_clk);
      check("leds", {4'b0000, bus.leds}, 8'(m_leds));
      check("mode", {6'b000000, bus.mode}, 8'(m_mode));
      check("tick", {7'b0000000, bus.tick}, 8'(m_tick));
    end
  endtask

  task automatic do_reset(input logic [3:0] sw, input int n);
    board_rst_n  = 1'b0;
    bus.switches = sw;
    model_reset();
    cycle(n);
    board_rst_n = 1'b1;
  endtask

  task automatic wait_leds(input string tag, input logic [3:0] target);
    int k;
    k = 0;
    while (bus.leds !== target && k < 200) begin
      cycle(1);
      k++;
    end
    check(tag, {4'b0000, bus.leds}, {4'b0000, target});
  endtask

  int hold;

  initial begin
    board_rst_n  = 1'b0;
    bus.switches = 4'b0000;
    model_reset();
    @(negedge board_clk);

    // Reset held with BOUNCE selected, then release: mode appears seven cycles later
    do_reset(4'b0010, 10);
    cycle(6);
    check("t1_mode_before", {6'b000000, bus.mode}, 8'h00);
    cycle(1);
    check("t1_mode_after", {6'b000000, bus.mode}, 8'h02);
    check("t1_leds_after", {4'b0000, bus.leds}, 8'h01);
    cycle(40);

    // COUNT up through a full wrap
    do_reset(4'b0001, 2);
    cycle(7);
    check("t2_mode", {6'b000000, bus.mode}, 8'h01);
    cycle(16 * DIV + 10);

    // COUNT down
    do_reset(4'b1001, 2);
    cycle(7 + DIV);
    check("t3_first_tick", {4'b0000, bus.leds}, 8'h0f);
    cycle(DIV);
    check("t3_second_tick", {4'b0000, bus.leds}, 8'h0e);

    // Short glitch in OFF, then pause in COUNT
    do_reset(4'b0000, 2);
    bus.switches = 4'b0001;
    cycle(3);
    bus.switches = 4'b0000;
    cycle(12);
    check("t5_glitch_mode", {6'b000000, bus.mode}, 8'h00);
    bus.switches = 4'b0001;
    cycle(7);
    wait_leds("t5_reach_0011", 4'b0011);
    bus.switches = 4'b0101;
    cycle(20);
    bus.switches = 4'b0001;
    cycle(25);

    // BLINK, then asynchronous reset between edges once leds = 1111
    do_reset(4'b0011, 2);
    cycle(7);
    wait_leds("t6_reach_1111", 4'b1111);
    #2;
    board_rst_n = 1'b0;
    model_reset();
    #1;
    check("t6_async_leds", {4'b0000, bus.leds}, 8'h00);
    check("t6_async_mode", {6'b000000, bus.mode}, 8'h00);
    @(negedge board_clk);
    cycle(2);
    board_rst_n = 1'b1;

    // BLINK entry with variant set
    bus.switches = 4'b1011;
    cycle(7);
    check("blink_variant_entry", {4'b0000, bus.leds}, 8'h05);
    cycle(20);

    // Random switch activity with occasional resets
    for (int it = 0; it < 150; it++) begin
      if ($urandom_range(0, 29) == 0) do_reset(4'($urandom_range(0, 15)), 2);
      bus.switches = 4'($urandom_range(0, 15));
      hold = $urandom_range(1, 40);
      cycle(hold);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/led_pattern_sequencer.md
Name: led_pattern_sequencer

Overview:
Board-level controller between the four slide switches and the four LEDs. It synchronises and debounces the switches, decodes them into a display mode, and runs a prescaled tick that steps a pattern state machine. The LED pattern engine is driven only by this sequencer. The block instantiates directly under top, on board_clk.

Parameters:
TICK_DIV, 25_000_000, board_clk cycles per pattern step (4 Hz at 100 MHz); legal range is 2 or more.
DEBOUNCE_CYCLES, 1_000_000, consecutive stable cycles required before a switch change is accepted (10 ms at 100 MHz); legal range is 1 or more.

Ports:
board_clk  in  1  board clock, 100 MHz; all logic is on the rising edge.
board_rst_n  in  1  asynchronous, active-low reset. Assertion takes effect immediately; release is sampled on board_clk.
switches  in  4  raw, asynchronous slide switches. [1:0] = mode, [2] = pause, [3] = variant.
leds  out  4  registered LED pattern.
mode  out  2  current debounced mode: 00 OFF, 01 COUNT, 10 BOUNCE, 11 BLINK.
tick  out  1  one-cycle strobe, asserted on each pattern step.

Behaviour:
Reset (while board_rst_n = 0):
- leds = 0000, mode = 00, tick = 0.
- State = OFF.
- Prescaler = 0 and debounce counters = 0.
- Synchroniser flops and debounced switch values = 0.

Input conditioning:
- Each switch bit passes through a 2-flop synchroniser.
- Each bit then has its own debounce counter. The counter increments while the synchronised bit differs from the debounced bit, and clears when they are equal.
- When the counter reaches DEBOUNCE_CYCLES, the debounced bit takes the new value and the counter clears.
- Latency from a stable raw change to the debounced value is 2 + DEBOUNCE_CYCLES cycles.
- A glitch shorter than DEBOUNCE_CYCLES cycles is never accepted.

Prescaler:
- Counts 0 to TICK_DIV-1 and wraps to 0.
- tick = 1 in the cycle where the count equals TICK_DIV-1 and the sequencer is running (state is not OFF and pause is 0).
- In OFF, the prescaler is held at 0.
- While pause is 1, the prescaler holds its value and tick = 0. On unpause it resumes from the held value.

State machine (states OFF, COUNT, BOUNCE_L, BOUNCE_R, BLINK):
- Mode change: a change of the debounced mode[1:0] is applied on the next edge. This loads the entry state and entry pattern and clears the prescaler. It takes priority over a coincident tick and is applied even while paused. The mode output follows on the same edge.
- Entry patterns:
  - 00 -> OFF, leds 0000.
  - 01 -> COUNT, leds 0000.
  - 10 -> BOUNCE_L, leds 0001.
  - 11 -> BLINK, leds 0000 if variant = 0, or 0101 if variant = 1.
- COUNT, on each tick:
  - variant = 0: leds + 1, wrapping 1111 -> 0000.
  - variant = 1: leds - 1, wrapping 0000 -> 1111.
  - The variant bit is sampled at each tick.
- BOUNCE_L, on each tick: if leds = 1000, load 0100 and go to BOUNCE_R; otherwise shift left by one.
- BOUNCE_R, on each tick: if leds = 0001, load 0010 and go to BOUNCE_L; otherwise shift right by one.
- Resulting bounce sequence: 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010, ...
- BLINK, on each tick: leds = ~leds.
- A variant change in BLINK takes effect only at the next mode entry.
- OFF: leds are held at 0000 and no ticks are produced.

Mid-operation reset:
- Asserting board_rst_n forces the reset values asynchronously, with no clock edge needed.
- After release, the block restarts from OFF. Any switches already high are re-debounced from 0.

Test Plan:
All scenarios use DEBOUNCE_CYCLES = 4, TICK_DIV = 5, and a 10 ns clock.

1. Reset: board_rst_n = 0 with switches = 0010 held for 10 cycles -> leds 0000, mode 00, tick 0 throughout. After release, mode becomes 10 and leds 0001 seven cycles after release.
2. COUNT up: switches 0001 from reset -> mode 01 and leds 0000 after 7 cycles. Then tick fires every 5 cycles and leds step 0001, 0010, ..., 1111, 0000 (wrap on the 16th tick).
3. COUNT down: switches 1001 -> the first tick gives leds 1111, the second 1110.
4. BOUNCE: switches 0010 -> leds on successive ticks are 0010, 0100, 1000, 0100, 0010, 0001, 0010. mode is 10 throughout.
5. Glitch and pause:
   - switches[0] pulsed high for 3 cycles in OFF -> mode stays 00.
   - In COUNT at leds = 0011, switches[2] held high for 20 cycles -> leds stay 0011 and tick stays 0. After release plus debounce, counting resumes with the prescaler continuing from its held value.
6. Async reset mid-BLINK at leds = 1111: board_rst_n dropped between clock edges -> leds 0000 and mode 00 immediately, before the next rising edge.
